// File: rtl/cp0_interrupt_unit.sv
// cp0_interrupt_unit
// MIPS CP0 register block: Status, Cause, EPC, BadVAddr, Count and Compare,
// with a divided Count timer, a Compare-match timer interrupt and sampled
// external hardware interrupts.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   write_enabled                mtc0 write strobe
//   address_register/_select     CP0 register number and select (read and write)
//   write_data                   mtc0 data
//   read_data                    mfc0 data, combinational from the address
//   exception_valid/_code/_address, in_delay_slot
//                                exception commit from writeback
//   bad_vaddr_valid, bad_vaddr   address-error faulting address
//   eret_flush                   eret commit
//   hw_interrupt                 level-sensitive external interrupt lines
//   interrupt_pending            masked interrupt request toward the pipeline
//   epc_out                      current EPC, toward instruction fetch
//   exception_level              Status.EXL
module cp0_interrupt_unit #(
   parameter int NUM_HW_INT   = 6,
   parameter int COUNT_DIV    = 2,
   parameter int TIMER_IP_BIT = 7
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_enabled,
   input  logic [4:0]            address_register,
   input  logic [2:0]            address_select,
   input  logic [31:0]           write_data,
   output logic [31:0]           read_data,
   input  logic                  exception_valid,
   input  logic [4:0]            exception_code,
   input  logic [31:0]           exception_address,
   input  logic                  in_delay_slot,
   input  logic                  bad_vaddr_valid,
   input  logic [31:0]           bad_vaddr,
   input  logic                  eret_flush,
   input  logic [NUM_HW_INT-1:0] hw_interrupt,
   output logic                  interrupt_pending,
   output logic [31:0]           epc_out,
   output logic                  exception_level
);

   localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

   localparam logic [4:0] REG_BADVADDR = 5'd8;
   localparam logic [4:0] REG_COUNT    = 5'd9;
   localparam logic [4:0] REG_COMPARE  = 5'd11;
   localparam logic [4:0] REG_STATUS   = 5'd12;
   localparam logic [4:0] REG_CAUSE    = 5'd13;
   localparam logic [4:0] REG_EPC      = 5'd14;

   logic [31:0]           count_reg;
   logic [31:0]           compare_reg;
   logic [31:0]           epc_reg;
   logic [31:0]           badvaddr_reg;
   logic [DIV_W-1:0]      div_reg;
   logic [7:0]            im_reg;
   logic                  exl_reg;
   logic                  ie_reg;
   logic                  bd_reg;
   logic                  ti_reg;
   logic [1:0]            ip_sw_reg;
   logic [4:0]            exc_code_reg;
   logic [NUM_HW_INT-1:0] hw_reg;

   // Register selects shared by read and write paths (select 0 only).
   logic sel_badvaddr, sel_count, sel_compare, sel_status, sel_cause, sel_epc;
   assign sel_badvaddr = (address_select == 3'd0) && (address_register == REG_BADVADDR);
   assign sel_count    = (address_select == 3'd0) && (address_register == REG_COUNT);
   assign sel_compare  = (address_select == 3'd0) && (address_register == REG_COMPARE);
   assign sel_status   = (address_select == 3'd0) && (address_register == REG_STATUS);
   assign sel_cause    = (address_select == 3'd0) && (address_register == REG_CAUSE);
   assign sel_epc      = (address_select == 3'd0) && (address_register == REG_EPC);

   // A committing exception squashes any mtc0 in the same cycle.
   logic wr_ok;
   assign wr_ok = write_enabled && !exception_valid;

   logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
   assign wr_count   = wr_ok && sel_count;
   assign wr_compare = wr_ok && sel_compare;
   assign wr_status  = wr_ok && sel_status;
   assign wr_cause   = wr_ok && sel_cause;
   assign wr_epc     = wr_ok && sel_epc;

   logic        div_wrap;
   logic [31:0] count_inc;
   logic        timer_match;
   assign div_wrap  = (div_reg == DIV_LAST);
   assign count_inc = count_reg + 32'd1;
   // A match is only an incrementing edge landing on Compare; a Count load
   // never raises TI even if it equals Compare.
   assign timer_match = div_wrap && !wr_count && (count_inc == compare_reg);

   // Cause.IP: [1:0] software, [7:2] registered hardware lines, with TI folded
   // into the chosen timer bit.
   logic [7:0] ip_full;
   assign ip_full[1:0] = ip_sw_reg;

   genvar gi;
   generate
      for (gi = 2; gi < 8; gi++) begin : g_ip
         logic hw_bit;
         if ((gi - 2) < NUM_HW_INT) begin : g_hw
            assign hw_bit = hw_reg[gi-2];
         end else begin : g_nohw
            assign hw_bit = 1'b0;
         end
         if (gi == TIMER_IP_BIT) begin : g_timer
            assign ip_full[gi] = hw_bit | ti_reg;
         end else begin : g_plain
            assign ip_full[gi] = hw_bit;
         end
      end
   endgenerate

   logic [31:0] status_value;
   logic [31:0] cause_value;
   assign status_value = {9'd0, 1'b1, 6'd0, im_reg, 6'd0, exl_reg, ie_reg};
   assign cause_value  = {bd_reg, ti_reg, 14'd0, ip_full, 1'b0, exc_code_reg, 2'b00};

   always_ff @(posedge clock) begin
      if (reset) begin
         count_reg    <= '0;
         compare_reg  <= '0;
         epc_reg      <= '0;
         badvaddr_reg <= '0;
         div_reg      <= '0;
         im_reg       <= '0;
         exl_reg      <= 1'b0;
         ie_reg       <= 1'b0;
         bd_reg       <= 1'b0;
         ti_reg       <= 1'b0;
         ip_sw_reg    <= '0;
         exc_code_reg <= '0;
         hw_reg       <= '0;
      end else begin
         hw_reg <= hw_interrupt;

         // Count load restarts the divider and replaces this cycle's increment.
         if (wr_count) begin
            count_reg <= write_data;
            div_reg   <= '0;
         end else if (div_wrap) begin
            count_reg <= count_inc;
            div_reg   <= '0;
         end else begin
            div_reg <= div_reg + DIV_W'(1);
         end

         // A Compare write beats a simultaneous match.
         if (wr_compare) begin
            compare_reg <= write_data;
            ti_reg      <= 1'b0;
         end else if (timer_match) begin
            ti_reg <= 1'b1;
         end

         if (wr_status) begin
            im_reg <= write_data[15:8];
            ie_reg <= write_data[0];
         end

         if (exception_valid) begin
            exl_reg <= 1'b1;
         end else if (eret_flush) begin
            exl_reg <= 1'b0;
         end else if (wr_status) begin
            exl_reg <= write_data[1];
         end

         if (wr_cause) begin
            ip_sw_reg <= write_data[9:8];
         end

         // Nested exceptions (EXL already set) keep the original EPC/BD.
         if (exception_valid) begin
            exc_code_reg <= exception_code;
            if (!exl_reg) begin
               bd_reg  <= in_delay_slot;
               epc_reg <= in_delay_slot ? (exception_address - 32'd4) : exception_address;
            end
            if (bad_vaddr_valid) begin
               badvaddr_reg <= bad_vaddr;
            end
         end else if (wr_epc) begin
            epc_reg <= write_data;
         end
      end
   end

   always_comb begin
      read_data = 32'd0;
      read_data = read_data | ({32{sel_badvaddr}} & badvaddr_reg);
      read_data = read_data | ({32{sel_count}}    & count_reg);
      read_data = read_data | ({32{sel_compare}}  & compare_reg);
      read_data = read_data | ({32{sel_status}}   & status_value);
      read_data = read_data | ({32{sel_cause}}    & cause_value);
      read_data = read_data | ({32{sel_epc}}      & epc_reg);
   end

   assign interrupt_pending = ie_reg && !exl_reg && (|(ip_full & im_reg));
   assign epc_out           = epc_reg;
   assign exception_level   = exl_reg;

endmodule

// File: doc/cp0_interrupt_unit.md
Name: cp0_interrupt_unit

Overview:
Parametrised successor to the MIPS CP0 register block in cpu_core. It holds Status, Cause, EPC, BadVAddr, Count and Compare, runs a divided Count timer with a Compare-match timer interrupt, and samples external hardware interrupts. It produces a masked interrupt-pending flag toward the pipeline. It sits beside the writeback stage, which issues mtc0 writes, exception commits and eret, and it feeds EPC to instruction fetch.

Parameters:
NUM_HW_INT, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+NUM_HW_INT-1:2]; unused IP bits read 0
COUNT_DIV, 2, clock cycles per Count increment (>=1)
TIMER_IP_BIT, 7, Cause.IP bit (2..7) ORed with Cause.TI

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
write_enabled  in  1  mtc0 write strobe
address_register  in  5  CP0 register number (read and write)
address_select  in  3  CP0 select (read and write)
write_data  in  32  mtc0 data
read_data  out  32  mfc0 data, combinational from address
exception_valid  in  1  exception commits this cycle
exception_code  in  5  ExcCode
exception_address  in  32  PC of the faulting instruction
in_delay_slot  in  1  faulting instruction is in a delay slot
bad_vaddr_valid  in  1  address-error exception; load BadVAddr
bad_vaddr  in  32  faulting virtual address
eret_flush  in  1  eret commits this cycle
hw_interrupt  in  NUM_HW_INT  level-sensitive external interrupts
interrupt_pending  out  1  Status.IE & ~Status.EXL & |(Cause.IP & Status.IM)
epc_out  out  32  current EPC
exception_level  out  1  Status.EXL

Behaviour:
- Register map (select 0): BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14. Any other address reads 0, and writes to it are ignored. read_data is a pure mux with no registered delay; unselected terms must contribute 0 (bitwise OR, not logical OR).
- Status: BEV is read-only and reads 1. IM[7:0], EXL and IE are writable. All other bits read 0. Reset values: IM=0, EXL=0, IE=0.
- EXL priority: exception_valid sets EXL=1; otherwise eret_flush clears EXL=0; otherwise an mtc0 to Status loads it.
- Cause: BD, TI, IP[7:0] and ExcCode; all other bits read 0. IP[1:0] are software-writable. IP[7:2] are read-only and take the registered hw_interrupt value, so latency is 1 cycle from pin to IP. IP[TIMER_IP_BIT] additionally ORs in TI. Reset: all fields 0.
- On exception_valid: ExcCode is always updated. BD and EPC are updated only when EXL==0 before the exception. EPC = in_delay_slot ? exception_address-4 : exception_address (32-bit wrap). BadVAddr loads bad_vaddr only when bad_vaddr_valid=1.
- An mtc0 in the same cycle as exception_valid is suppressed entirely.
- EPC is mtc0-writable. BadVAddr is read-only. EPC and BadVAddr reset to 0.
- Count: a divider counter runs 0..COUNT_DIV-1; Count increments by 1 on each divider wrap and wraps 0xFFFFFFFF->0.
- An mtc0 to Count loads the value, restarts the divider at 0, and suppresses that cycle's increment. Count and the divider reset to 0.
- Compare: resets to 0. An mtc0 to Compare loads the value and clears TI in the same edge.
- TI sets, and stays set, on the edge where Count increments to a value equal to Compare. It clears only on a Compare write or reset.
- If a Compare write coincides with a match, the write wins and TI=0. A Count write that equals Compare does not set TI.
- interrupt_pending is combinational from registers and is 0 after reset.
- Reset mid-operation returns every register above to its reset value on that edge. The divider phase is lost.

Test Plan:
- Reset, then read Status/Cause/EPC/Count -> 0x00400000, 0, 0, 0; interrupt_pending=0.
- COUNT_DIV=2, Compare=5 written at Count=0, run -> Count reaches 5 after 10 cycles; TI=1 and Cause bit 30 and IP7 set the same edge. Set Status=0x00008001 -> interrupt_pending=1. Write Compare=20 -> TI=0 next cycle.
- hw_interrupt[0]=1 with IM2=1, IE=1, EXL=0 -> Cause.IP2=1 and interrupt_pending=1 one cycle later. Deassert -> both clear one cycle later.
- exception_valid with addr 0xBFC00104, in_delay_slot=1, code 4, bad_vaddr_valid=1, bad_vaddr 0x1003 -> EPC=0xBFC00100, BD=1, ExcCode=4, BadVAddr=0x1003, EXL=1. A second exception (addr 0x80000000) leaves EPC and BD unchanged and updates ExcCode. eret -> EXL=0.
- Same cycle mtc0 Status=0 and exception_valid -> IE/IM unchanged, EXL=1. Count write 0xFFFFFFFF -> Count wraps to 0 after COUNT_DIV cycles.
- Read address 10 or select 1 -> read_data=0. A write to Compare equal to the current Count does not set TI until the next match.
